// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the mm:ss stopwatch: FSM states, digit width and
// active-high 7-segment patterns (bit 0 = segment a).
package stopwatch_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  localparam int unsigned DigitW = 4;

  localparam logic [6:0] SegDigits [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  localparam logic [6:0] SegBlank = 7'h00;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to 7-segment decoder; values 10..15 show blank.
module bcd_to_7seg
  import stopwatch_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [DigitW-1:0] nibble_i,
  output logic [6:0]        seg_o
);

  logic [6:0] seg_hi;

  always_comb begin
    seg_hi = SegBlank;
    if (nibble_i <= 4'd9) seg_hi = SegDigits[nibble_i];
    seg_o = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
  end

endmodule

// File: rtl/stopwatch_display.sv
// mm:ss BCD stopwatch with run/pause/clear and four 7-segment outputs.
// Define STOPWATCH_LAP_EN to add the lap (display freeze) feature.
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter int unsigned MIN_WRAP       = 60
) (
  input  logic        CLOCK_50,
  input  logic        KEY,
  input  logic        tick,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [15:0] bcd,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic        LEDG,
  output logic        wrap
);

  localparam logic [DigitW-1:0] LastM1 = DigitW'((MIN_WRAP - 1) / 10);
  localparam logic [DigitW-1:0] LastM0 = DigitW'((MIN_WRAP - 1) % 10);

`ifdef STOPWATCH_LAP_EN
  localparam int unsigned NumBtn = 3;
  logic [NumBtn-1:0] btn_raw;
  assign btn_raw = {lap, clear, start_stop};
`else
  localparam int unsigned NumBtn = 2;
  logic [NumBtn-1:0] btn_raw;
  logic              unused_lap;
  assign btn_raw    = {clear, start_stop};
  assign unused_lap = lap;
`endif

  logic [NumBtn-1:0] sync1_q, sync2_q, prev_q, evt_q;

  // Chain resets to "held" so a button held through reset release yields no event.
  always_ff @(posedge CLOCK_50 or posedge KEY) begin
    if (KEY) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
      evt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      evt_q   <= sync2_q & ~prev_q;
    end
  end

  logic ss_evt, clr_evt;
  assign ss_evt  = evt_q[0];
  assign clr_evt = evt_q[1];

  state_e state_q, state_d;
  logic   clr_digits;

  always_comb begin
    state_d    = state_q;
    clr_digits = 1'b0;
    unique case (state_q)
      StIdle:  if (ss_evt) state_d = StRun;
      StRun:   if (ss_evt) state_d = StPause;
      StPause: begin
        if (ss_evt) begin
          state_d = StRun;
        end else if (clr_evt) begin
          state_d    = StIdle;
          clr_digits = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  logic [DigitW-1:0] s0_q, s1_q, m0_q, m1_q, s0_d, s1_d, m0_d, m1_d;
  logic              wrap_q, wrap_d;

  always_comb begin
    s0_d   = s0_q;
    s1_d   = s1_q;
    m0_d   = m0_q;
    m1_d   = m1_q;
    wrap_d = 1'b0;
    if (clr_digits) begin
      s0_d = '0;
      s1_d = '0;
      m0_d = '0;
      m1_d = '0;
    end else if (tick && state_q == StRun) begin
      if (s0_q != 4'd9) begin
        s0_d = s0_q + 4'd1;
      end else begin
        s0_d = '0;
        if (s1_q != 4'd5) begin
          s1_d = s1_q + 4'd1;
        end else begin
          s1_d = '0;
          if (m1_q == LastM1 && m0_q == LastM0) begin
            m1_d   = '0;
            m0_d   = '0;
            wrap_d = 1'b1;
          end else if (m0_q != 4'd9) begin
            m0_d = m0_q + 4'd1;
          end else begin
            m0_d = '0;
            m1_d = m1_q + 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge KEY) begin
    if (KEY) begin
      state_q <= StIdle;
      s0_q    <= '0;
      s1_q    <= '0;
      m0_q    <= '0;
      m1_q    <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      m0_q    <= m0_d;
      m1_q    <= m1_d;
      wrap_q  <= wrap_d;
    end
  end

  logic [15:0] live_bcd;
  assign live_bcd = {m1_q, m0_q, s1_q, s0_q};
  assign LEDG     = (state_q == StRun);
  assign wrap     = wrap_q;

`ifdef STOPWATCH_LAP_EN
  logic        frozen_q, frozen_d;
  logic [15:0] lap_q, lap_d;

  always_comb begin
    frozen_d = frozen_q;
    lap_d    = lap_q;
    if (clr_digits) begin
      frozen_d = 1'b0;
    end else if (evt_q[2] && state_q == StRun) begin
      frozen_d = ~frozen_q;
      if (!frozen_q) lap_d = live_bcd;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge KEY) begin
    if (KEY) begin
      frozen_q <= 1'b0;
      lap_q    <= '0;
    end else begin
      frozen_q <= frozen_d;
      lap_q    <= lap_d;
    end
  end

  assign bcd = frozen_q ? lap_q : live_bcd;
`else
  assign bcd = live_bcd;
`endif

  bcd_to_7seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_hex0 (.nibble_i(bcd[3:0]),   .seg_o(HEX0));
  bcd_to_7seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_hex1 (.nibble_i(bcd[7:4]),   .seg_o(HEX1));
  bcd_to_7seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_hex2 (.nibble_i(bcd[11:8]),  .seg_o(HEX2));
  bcd_to_7seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_hex3 (.nibble_i(bcd[15:12]), .seg_o(HEX3));

endmodule

// File: doc/stopwatch_display.md
# stopwatch_display

Downstream consumer of the one-second tick produced by the 50 MHz counter/comparator stage. It counts elapsed time as mm:ss in four BCD digits, lets the user run, pause and clear, and drives four 7-segment displays plus a run indicator LED. It sits between the one-second tick generator and the board's HEX/LEDG pins.

## Interface
- SEG_ACTIVE_LOW, default 1: 1 means segment outputs are active-low, as on the board; 0 means active-high.
- MIN_WRAP, default 60: the minutes value at which the count wraps to 00:00. Legal range is 1..60.

- CLOCK_50  in  1  system clock, 50 MHz. All logic is on the rising edge.
- KEY  in  1  reset, asynchronous, active-high. Clears all state immediately.
- tick  in  1  one-cycle pulse, once per second, synchronous to CLOCK_50.
- start_stop  in  1  level from a pushbutton, asynchronous; the rising edge is the event.
- clear  in  1  level, asynchronous; the rising edge is the event.
- lap  in  1  level, asynchronous; the rising edge is the event. Used only when STOPWATCH_LAP_EN is defined.
- bcd  out  16  displayed digits {m1,m0,s1,s0}, 4 bits each.
- HEX0..HEX3  out  7 each  segments for s0, s1, m0, m1; bit 0 is segment a.
- LEDG  out  1  1 while in RUN.
- wrap  out  1  one-cycle pulse when the count rolls over to 00:00.

## Operation
- Input conditioning:
  - start_stop, clear and lap each pass through a 2-flop synchronizer, then a rising-edge detector.
  - Each detector produces a one-cycle event. One press gives exactly one event.
- State machine, states IDLE, RUN, PAUSE:
  - IDLE: start_stop goes to RUN; clear does nothing.
  - RUN: start_stop goes to PAUSE; clear is ignored.
  - PAUSE: start_stop goes back to RUN; clear zeroes all digits and goes to IDLE.
- Counting:
  - A tick is counted only when the current, pre-transition state is RUN.
  - A tick in the same cycle as a start_stop event in RUN is counted.
  - A tick in the same cycle as a start_stop event in IDLE or PAUSE is not counted.
- Digit arithmetic is a cascaded BCD count:
  - s0 runs 0..9. When s0=9, s0 goes to 0 and s1 increments.
  - s1 runs 0..5.
  - Minutes {m1,m0} run 00..MIN_WRAP-1.
  - At MIN_WRAP-1:59, a tick sets all digits to 0 and pulses wrap for one cycle.
  - Digit registers never hold a value above 9.
- HEX outputs:
  - Each HEX output is a combinational decode of its bcd nibble.
  - Segment polarity follows SEG_ACTIVE_LOW.
- Reset asserted mid-operation: state goes to IDLE, digits to 0, synchronizers and edge detectors clear. No event is generated when reset is released while a button is held.

## Timing
- Reset values:
  - bcd=16'h0000, LEDG=0, wrap=0.
  - With SEG_ACTIVE_LOW=1, HEX0..HEX3 = 7'b1000000 (the digit "0").
- Tick to bcd: tick sampled at edge n gives the updated bcd after edge n, a latency of 1 cycle.
- wrap asserts in the same cycle that bcd becomes 0000.
- Button to state change: an input rising edge before edge n is seen as an event after edge n+2. The state updates after edge n+3, so LEDG changes 3 cycles after the input edge.
- No handshake: tick is trusted to be a single-cycle pulse. A tick held high for k cycles counts k times.

## Configuration
- The macro is STOPWATCH_LAP_EN.
- When defined:
  - A lap event in RUN freezes the display: bcd and HEX hold the value latched on the lap event while the internal count continues.
  - A second lap event releases the freeze, and the display shows the live count on the next cycle.
  - The freeze also releases when clear takes PAUSE to IDLE. A lap event in PAUSE or IDLE is ignored.
  - wrap is always driven from the live count.
- When undefined: the lap port remains on the interface but is unused. bcd always shows the live count, and no lap logic is synthesized.

## Structure
- Shared package, stopwatch_pkg, holds:
  - the state enum {IDLE, RUN, PAUSE};
  - the BCD digit width (4);
  - the 7-segment patterns for 0..9, stored active-high;
  - the blank pattern, used for nibble values 10..15.
- One sub-module, bcd_to_7seg: a combinational nibble-to-segment decoder with SEG_ACTIVE_LOW. It is instantiated four times.

## Test plan
- Reset with KEY=1, then release:
  - bcd=0000, HEX0=7'b1000000, LEDG=0.
  - A press of start_stop gives LEDG=1 three cycles after the input edge.
- In RUN, apply 61 ticks: bcd=16'h0101 (01:01), and wrap is never asserted.
- MIN_WRAP=60, count preloaded to 59:58 by ticking, 2 ticks: bcd=0000 after the second tick, and wrap is high for exactly 1 cycle.
- Pause, then apply 5 ticks: bcd is unchanged. A clear press gives bcd=0000 and state IDLE. A clear press during RUN changes nothing.
- Reset asserted mid-count at 12:34: all outputs return to reset values asynchronously, before the next clock edge.
- With STOPWATCH_LAP_EN, press lap at 00:10, then apply 5 ticks: bcd holds 0010. A second lap press makes bcd show 0015 on the next cycle.
